fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu_pkg.sv | 13 +
 rtl/fetch_pc_reg.sv | 26 ++
 rtl/fetch_unit.sv | 170 +++++++++++++++++
 tb/tb_fetch_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset PC, nop word and
// the fetch state encoding used by fetch_unit.
package cpu_pkg;

    localparam logic [31:0] PC_INIT_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] NOP_WORD        = 32'h0000_0000;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_REQ  = 2'b01;
    localparam logic [1:0] ST_WAIT = 2'b10;
    localparam logic [1:0] ST_HOLD = 2'b11;

endpackage

// File: rtl/fetch_pc_reg.sv
// Fetch PC register: reset value, redirect load
// (highest priority) and sequential +4 increment.
module fetch_pc_reg
    import cpu_pkg::*;
#(
    parameter logic [31:0] PC_INIT = PC_INIT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        inc,
    input  logic [31:0] target,
    output logic [31:0] pc
);

    // Redirect beats increment; +4 wraps modulo 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pc <= PC_INIT;
        else if (load)
            pc <= target;
        else if (inc)
            pc <= pc + 32'd4;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM with a one-entry IR buffer.
// Optional macro FETCH_ALIGN_CHECK_EN: misaligned redirect raises AdEL.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] PC_INIT = PC_INIT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stalk,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        ImReq,
    output logic [31:0] ImAddr,
    input  logic        ImGnt,
    input  logic        ImRvalid,
    input  logic [31:0] ImRdata,
    output logic [31:0] NextIDIR,
    output logic [31:0] NextIDPC,
    output logic [31:0] NextIDPC_8,
    output logic        FetchValid,
    output logic        AdEL
);

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [31:0] pc;
    logic [31:0] ir_buf;
    logic [31:0] target;
    logic        drop;
    logic        drop_nxt;
    logic        pc_load;
    logic        pc_inc;
    logic        buf_load;
    logic        buf_clr;
    logic        mis;
    logic        granted;

`ifdef FETCH_ALIGN_CHECK_EN
    logic adel;

    assign target = RedirectPC;
    assign mis    = Redirect && (RedirectPC[1:0] != 2'b00);
    assign AdEL   = adel && FetchValid;

    // AdEL tracks the last redirect until the
    // presented word is consumed or replaced.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            adel <= 1'b0;
        else if (Redirect)
            adel <= mis;
        else if (buf_load || pc_inc)
            adel <= 1'b0;
    end
`else
    assign target = RedirectPC & ~32'h3;
    assign mis    = 1'b0;
    assign AdEL   = 1'b0;
`endif

    // A pending drop blocks new requests so at most
    // one request is ever outstanding.
    assign ImReq   = (state == ST_REQ) && !drop;
    assign ImAddr  = pc;
    assign granted = ImReq && ImGnt;

    assign FetchValid = (state == ST_HOLD);
    assign NextIDIR   = FetchValid ? ir_buf : NOP_WORD;
    assign NextIDPC   = FetchValid ? pc : NOP_WORD;
    assign NextIDPC_8 = FetchValid ? pc + 32'd8 : NOP_WORD;

    fetch_pc_reg #(
        .PC_INIT (PC_INIT)
    ) u_pc (
        .clk    (clk),
        .reset  (reset),
        .load   (pc_load),
        .inc    (pc_inc),
        .target (target),
        .pc     (pc)
    );

    // Next-state logic; Redirect wins over grant and consume.
    always_comb begin
        state_nxt = state;
        drop_nxt  = drop;
        pc_load   = 1'b0;
        pc_inc    = 1'b0;
        buf_load  = 1'b0;
        buf_clr   = 1'b0;
        if (drop && ImRvalid)
            drop_nxt = 1'b0;
        case (state)
            ST_IDLE: state_nxt = ST_REQ;
            ST_REQ: begin
                if (Redirect) begin
                    pc_load = 1'b1;
                    if (granted)
                        drop_nxt = 1'b1;
                    if (mis) begin
                        state_nxt = ST_HOLD;
                        buf_clr   = 1'b1;
                    end else if (granted) begin
                        state_nxt = ST_WAIT;
                    end
                end else if (granted) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (drop) begin
                    if (Redirect)
                        pc_load = 1'b1;
                    if (mis) begin
                        state_nxt = ST_HOLD;
                        buf_clr   = 1'b1;
                    end else if (ImRvalid) begin
                        state_nxt = ST_REQ;
                    end
                end else if (Redirect) begin
                    pc_load  = 1'b1;
                    drop_nxt = !ImRvalid;
                    if (mis) begin
                        state_nxt = ST_HOLD;
                        buf_clr   = 1'b1;
                    end else if (ImRvalid) begin
                        state_nxt = ST_REQ;
                    end
                end else if (ImRvalid) begin
                    buf_load  = 1'b1;
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (Redirect) begin
                    pc_load   = 1'b1;
                    buf_clr   = 1'b1;
                    state_nxt = mis ? ST_HOLD : ST_REQ;
                end else if (!Stalk) begin
                    pc_inc    = 1'b1;
                    state_nxt = ST_REQ;
                end
            end
        endcase
    end

    // FSM state and response-drop flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            drop  <= 1'b0;
        end else begin
            state <= state_nxt;
            drop  <= drop_nxt;
        end
    end

    // IR buffer: captured on a live response,
    // cleared to a nop when discarded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ir_buf <= NOP_WORD;
        else if (buf_clr)
            ir_buf <= NOP_WORD;
        else if (buf_load)
            ir_buf <= ImRdata;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed fetch,
// stall, redirect, wrap and reset scenarios.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Stalk = 1'b0;
    logic        Redirect = 1'b0;
    logic [31:0] RedirectPC = 32'h0;
    logic        ImReq;
    logic [31:0] ImAddr;
    logic        ImGnt = 1'b0;
    logic        ImRvalid = 1'b0;
    logic [31:0] ImRdata = 32'h0;
    logic [31:0] NextIDIR;
    logic [31:0] NextIDPC;
    logic [31:0] NextIDPC_8;
    logic        FetchValid;
    logic        AdEL;

    int checks = 0;
    int failures = 0;
    logic [63:0] sb[$];

    fetch_unit u_dut (
        .clk        (clk),
        .reset      (reset),
        .Stalk      (Stalk),
        .Redirect   (Redirect),
        .RedirectPC (RedirectPC),
        .ImReq      (ImReq),
        .ImAddr     (ImAddr),
        .ImGnt      (ImGnt),
        .ImRvalid   (ImRvalid),
        .ImRdata    (ImRdata),
        .NextIDIR   (NextIDIR),
        .NextIDPC   (NextIDPC),
        .NextIDPC_8 (NextIDPC_8),
        .FetchValid (FetchValid),
        .AdEL       (AdEL)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_req(input int max);
        int n = 0;
        while (!ImReq && n < max) begin
            @(negedge clk);
            n++;
        end
        if (!ImReq)
            chk("req_timeout", {31'b0, ImReq}, 32'd1);
    endtask

    task automatic do_fetch(input logic [31:0] addr,
                            input logic [31:0] data);
        wait_req(20);
        chk("im_addr", ImAddr, addr);
        ImGnt = 1'b1;
        @(negedge clk);
        ImGnt = 1'b0;
        chk("no_req_in_wait", {31'b0, ImReq}, 32'd0);
        ImRvalid = 1'b1;
        ImRdata  = data;
        sb.push_back({addr, data});
        @(negedge clk);
        ImRvalid = 1'b0;
    endtask

    task automatic check_fetch();
        logic [63:0] e;
        chk("fetch_valid", {31'b0, FetchValid}, 32'd1);
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("next_ir", NextIDIR, e[31:0]);
            chk("next_pc", NextIDPC, e[63:32]);
            chk("next_pc8", NextIDPC_8, e[63:32] + 32'd8);
        end
    endtask

    task automatic stale_rvalid();
        ImRvalid = 1'b1;
        ImRdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        ImRvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_req", {31'b0, ImReq}, 32'd0);
        chk("rst_fv", {31'b0, FetchValid}, 32'd0);
        chk("rst_adel", {31'b0, AdEL}, 32'd0);
        chk("rst_ir", NextIDIR, 32'h0);
        chk("rst_pc", NextIDPC, 32'h0);
        chk("rst_pc8", NextIDPC_8, 32'h0);
        chk("rst_addr", ImAddr, 32'h3000);
        reset = 1'b0;
        @(negedge clk);

        // basic fetch and minimum latency
        do_fetch(32'h3000, 32'h2408_0001);
        check_fetch();

        // stall holds outputs, no new request
        Stalk = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stl_fv", {31'b0, FetchValid}, 32'd1);
            chk("stl_ir", NextIDIR, 32'h2408_0001);
            chk("stl_pc", NextIDPC, 32'h3000);
            chk("stl_req", {31'b0, ImReq}, 32'd0);
        end
        Stalk = 1'b0;
        @(negedge clk);
        chk("stl_next", ImAddr, 32'h3004);
        do_fetch(32'h3004, 32'h8C09_0004);
        check_fetch();

        // grant withheld: request stable
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("hold_req", {31'b0, ImReq}, 32'd1);
            chk("hold_addr", ImAddr, 32'h3008);
            @(negedge clk);
        end
        do_fetch(32'h3008, 32'h0000_0008);
        check_fetch();

        // redirect in WAIT drops old response
        @(negedge clk);
        chk("w_addr", ImAddr, 32'h300C);
        ImGnt = 1'b1;
        @(negedge clk);
        ImGnt      = 1'b0;
        Redirect   = 1'b1;
        RedirectPC = 32'h3100;
        @(negedge clk);
        Redirect = 1'b0;
        chk("w_req", {31'b0, ImReq}, 32'd0);
        stale_rvalid();
        chk("w_fv", {31'b0, FetchValid}, 32'd0);
        chk("w_req2", {31'b0, ImReq}, 32'd1);
        chk("w_addr2", ImAddr, 32'h3100);
        do_fetch(32'h3100, 32'h1111_0001);
        check_fetch();

        // redirect beats consume in HOLD
        Redirect   = 1'b1;
        RedirectPC = 32'h3200;
        @(negedge clk);
        Redirect = 1'b0;
        chk("h_fv", {31'b0, FetchValid}, 32'd0);
        chk("h_addr", ImAddr, 32'h3200);
        chk("h_ir", NextIDIR, 32'h0);

        // redirect with same-cycle grant
        Redirect   = 1'b1;
        RedirectPC = 32'h3300;
        ImGnt      = 1'b1;
        @(negedge clk);
        Redirect = 1'b0;
        ImGnt    = 1'b0;
        chk("rg_req", {31'b0, ImReq}, 32'd0);
        stale_rvalid();
        chk("rg_fv", {31'b0, FetchValid}, 32'd0);
        do_fetch(32'h3300, 32'h2222_0002);
        check_fetch();

        // PC wrap
        Redirect   = 1'b1;
        RedirectPC = 32'hFFFF_FFFC;
        @(negedge clk);
        Redirect = 1'b0;
        do_fetch(32'hFFFF_FFFC, 32'h3333_0003);
        check_fetch();
        @(negedge clk);
        chk("wrap_addr", ImAddr, 32'h0);

        // misaligned redirect
        Redirect   = 1'b1;
        RedirectPC = 32'h3002;
        @(negedge clk);
        Redirect = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        chk("al_adel", {31'b0, AdEL}, 32'd1);
        chk("al_fv", {31'b0, FetchValid}, 32'd1);
        chk("al_ir", NextIDIR, 32'h0);
        chk("al_pc", NextIDPC, 32'h3002);
        chk("al_req", {31'b0, ImReq}, 32'd0);
`else
        chk("al_adel", {31'b0, AdEL}, 32'd0);
        chk("al_req", {31'b0, ImReq}, 32'd1);
        chk("al_addr", ImAddr, 32'h3000);
`endif

        // reset mid-transaction, stale response
        wait_req(20);
        ImGnt = 1'b1;
        @(negedge clk);
        ImGnt = 1'b0;
        reset = 1'b1;
        #1;
        chk("mr_req", {31'b0, ImReq}, 32'd0);
        chk("mr_fv", {31'b0, FetchValid}, 32'd0);
        chk("mr_addr", ImAddr, 32'h3000);
        @(negedge clk);
        reset = 1'b0;
        stale_rvalid();
        chk("mr_fv2", {31'b0, FetchValid}, 32'd0);
        chk("mr_req2", {31'b0, ImReq}, 32'd1);
        do_fetch(32'h3000, 32'h4444_0004);
        check_fetch();
        chk("sb_drain", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
